// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_pkg
// Brief   : Shared types and constants for the 50%-duty clock divider.
// Rev     : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int DEFAULT_W = 4;
    localparam int MIN_DIV   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/clk_div_core.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_core
// Brief   : Posedge counter plus negedge half-cycle register forming div_out.
// Rev     : 1.0 - initial release
// ============================================================================
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] ratio,
    input  logic         run,
    input  logic         load,
    output logic         wrap,
    output logic         zero,
    output logic         div_out
);

    localparam logic [W-1:0] c_one = W'(1);

    logic [W-1:0] r_cnt_p;
    logic [W-1:0] w_cnt_next;
    logic         r_pos_hi;
    logic         r_neg_hi;
    logic         r_zero;

    assign wrap = (r_cnt_p == (ratio - c_one));

    always_comb begin
        w_cnt_next = wrap ? '0 : (r_cnt_p + c_one);
    end

    // A new period always starts with cnt 0, which is below any legal half ratio.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_p  <= '0;
            r_pos_hi <= 1'b0;
            r_zero   <= 1'b0;
        end else if (!run) begin
            r_cnt_p  <= '0;
            r_pos_hi <= 1'b0;
            r_zero   <= 1'b0;
        end else if (load) begin
            r_cnt_p  <= '0;
            r_pos_hi <= 1'b1;
            r_zero   <= 1'b1;
        end else begin
            r_cnt_p  <= w_cnt_next;
            r_pos_hi <= (w_cnt_next < (ratio >> 1));
            r_zero   <= (w_cnt_next == '0);
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_neg_hi <= 1'b0;
        end else begin
            r_neg_hi <= r_pos_hi;
        end
    end

    // Odd ratios stretch the high phase by half a cycle via the negedge copy.
    assign div_out = ratio[0] ? (r_pos_hi | r_neg_hi) : r_pos_hi;
    assign zero    = r_zero;

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_ctrl
// Brief   : Start/stop/ratio sequencing and config handshake for clk_div_core.
// Rev     : 1.0 - initial release
// ============================================================================
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int W           = DEFAULT_W,
    parameter int DEFAULT_DIV = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         div_out,
    output logic         tick,
    output logic [W-1:0] active_div,
    output logic         running
);

    localparam logic [W-1:0] c_default_div = W'(DEFAULT_DIV);
    localparam logic [W-1:0] c_min_div     = W'(MIN_DIV);

    state_t       r_state;
    logic         r_pend;
    logic [W-1:0] r_pend_div;
    logic [W-1:0] r_active_div;
    logic         r_cfg_err;
    logic         r_running;

    logic         w_xfer;
    logic         w_legal;
    logic         w_wrap;
    logic         w_zero;
    logic         w_run;
    logic         w_load;

    assign w_xfer  = cfg_valid & ~r_pend;
    assign w_legal = (cfg_div >= c_min_div);

    // True when the state after this edge is RUN or DRAIN.
    assign w_run  = en | (r_state == RUN) | ((r_state == DRAIN) & ~w_wrap);
    assign w_load = (r_state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_pend       <= 1'b0;
            r_pend_div   <= '0;
            r_active_div <= c_default_div;
            r_cfg_err    <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            r_cfg_err <= w_xfer & ~w_legal;
            r_running <= w_run;
            case (r_state)
                IDLE: begin
                    if (w_xfer & w_legal) begin
                        r_active_div <= cfg_div;
                    end
                    if (en) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (en) begin
                        r_state <= RUN;
                    end else if (w_wrap) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // A ratio pending at a wrap is applied there; one arriving on the wrap waits.
            if (r_state != IDLE) begin
                if (w_wrap & r_pend) begin
                    r_active_div <= r_pend_div;
                    r_pend       <= 1'b0;
                end else if (w_xfer & w_legal) begin
                    r_pend     <= 1'b1;
                    r_pend_div <= cfg_div;
                end
            end
        end
    end

    clk_div_core #(
        .W (W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .ratio   (r_active_div),
        .run     (w_run),
        .load    (w_load),
        .wrap    (w_wrap),
        .zero    (w_zero),
        .div_out (div_out)
    );

    assign cfg_ready  = ~r_pend;
    assign cfg_err    = r_cfg_err;
    assign tick       = w_zero;
    assign active_div = r_active_div;
    assign running    = r_running;

endmodule
`default_nettype wire

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Programmable 50%-duty clock divider controller, supporting odd and even ratios.
- Sequences start, stop and ratio changes of a posedge/negedge counter pair so that `div_out` never glitches or produces a runt pulse.
- Config arrives on a valid/ready handshake and takes effect only at an output-period boundary.
- Sits between the register/config logic and any consumer of a divided clock or enable.

Parameters:
- W, 4, width of the divide ratio and counters; legal ratios 2..2^W-1.
- DEFAULT_DIV, 5, ratio loaded at reset; must lie in 2..2^W-1.

Ports:
- clk  in  1  reference clock; both edges used.
- rst  in  1  asynchronous reset, active-low; resets both edge domains.
- en  in  1  run request; level-sensitive.
- cfg_valid  in  1  new ratio offered.
- cfg_div  in  W  offered ratio.
- cfg_ready  out  1  high when no ratio is pending.
- cfg_err  out  1  one-cycle pulse: accepted ratio was illegal (<2) and was dropped.
- div_out  out  1  divided output, 50% duty.
- tick  out  1  high for the clk cycle in which cnt_p==0 while running (period start).
- active_div  out  W  ratio currently in effect.
- running  out  1  high in RUN or DRAIN.

Behaviour:
- Reset (rst=0):
  - state=IDLE, cnt_p=0, pos_hi=0, neg_hi=0, pend=0.
  - active_div=DEFAULT_DIV.
  - div_out=0, tick=0, cfg_ready=1, cfg_err=0, running=0.
  - Release is sampled at the next posedge. Reset mid-period cuts div_out low immediately; this is the only permitted runt.
- States:
  - IDLE: counters at 0, div_out=0. en=1 at a posedge moves to RUN and, in that same edge, sets cnt_p=0 and pos_hi=1, so div_out rises after that posedge.
  - RUN: cnt_p counts 0..N-1 and wraps, where N=active_div. If en=0 at any edge, go to DRAIN.
  - DRAIN: keep counting until the wrap edge (cnt_p==N-1), then go to IDLE with cnt_p=0 and div_out=0. If en returns high during DRAIN, go back to RUN with no disturbance to the current period.
- Waveform generation:
  - Let H=N>>1. The posedge register is pos_hi_next = (cnt_p_next < H).
  - The negedge register neg_hi samples pos_hi on every negedge.
  - N even: div_out = pos_hi. High for N/2 cycles.
  - N odd: div_out = pos_hi | neg_hi. High for (N-1)/2 + 0.5 cycles, e.g. 2.5 cycles for N=5.
  - Period is exactly N clk cycles. Rising edges of div_out are always aligned to clk posedges.
- Config handshake:
  - Transfer occurs at a posedge where cfg_valid & cfg_ready.
  - Legal cfg_div (>=2):
    - In IDLE it is applied to active_div at that edge; pend stays 0.
    - In RUN or DRAIN, pend=1, it is stored, and cfg_ready=0 until applied.
  - Illegal cfg_div (0 or 1): the transfer completes, cfg_err pulses on the next cycle, and active_div and pend are unchanged.
- Ratio switch:
  - Occurs at the wrap edge: cnt_p←0 and active_div←pending, and the new period uses the new N. No partial period is ever output.
  - A transfer accepted on a wrap edge is applied at the following wrap, not the same one.
  - A pending ratio at the DRAIN→IDLE wrap is applied on that edge.
  - cfg_ready returns high the cycle after the switch.
- tick is registered in the posedge domain. Its first assertion is on the first RUN cycle.
- Counter width is W. Comparisons are unsigned. cnt_p never exceeds N-1.

Decomposition:
- Shared package clk_div_pkg holds:
  - the state enum {IDLE, RUN, DRAIN};
  - MIN_DIV=2;
  - default W.
- One natural sub-module, clk_div_core:
  - Contains cnt_p, pos_hi, the negedge neg_hi register and the odd/even output mux.
  - Inputs: ratio, run, load.
  - Outputs: wrap, cnt_p==0, div_out.
- clk_div_ctrl owns the FSM, the handshake, pend and active_div.

Test Plan:
- Reset held, then released with en=1 and N=5 → div_out period 5 clk, high 2.5 clk, rising edge 1 posedge after en sampled; tick every 5th cycle; active_div=5.
- cfg_div=4 accepted in IDLE, then en=1 → period 4, high exactly 2 clk; cfg_ready stays 1.
- Running at N=5, cfg_div=3 accepted at cnt_p=1 → cfg_ready=0; the current period completes at 5 cycles; the next period is 3 cycles with 1.5 high; cfg_ready=1 afterwards.
- en dropped at cnt_p=2 of N=7 → period completes (3.5 high, 7 total), then IDLE, div_out=0, running=0.
- cfg_div=1 offered while running → transfer completes, cfg_err pulses for 1 cycle, active_div unchanged, waveform undisturbed.
- rst asserted mid-high of N=5 → div_out, tick and running go to 0 immediately, without waiting for a clk edge; after release, active_div=DEFAULT_DIV and the block restarts cleanly.
